countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//   Loadable MM:SS countdown timer; decrements once per second to 00:00 and flags expiry.
//   Complements the up-counting stopwatch and reuses its start/stop control style.
//   Single clock domain: the 1 Hz tick is an internal clock enable, not a derived clock.
//   Sits beside the stopwatch and feeds the same display mux / alarm logic.
// PARAMETERS
//   TICK_DIV  12_000_000  clk cycles per 1 s tick (>=2); bench uses 4
//   MIN_W     6           width of minutes field (max 2**MIN_W-1)
// PORTS
//   clk       in   1      system clock, all logic on posedge
//   rst       in   1      synchronous, active-high reset
//   load      in   1      load load_min/load_sec, enter IDLE
//   load_min  in   MIN_W  preset minutes
//   load_sec  in   6      preset seconds (values >59 clamp to 59)
//   start     in   1      begin/resume countdown
//   stop      in   1      pause countdown
//   min       out  MIN_W  current minutes
//   sec       out  6      current seconds, 0..59
//   running   out  1      1 while state==RUN
//   done      out  1      single-cycle pulse on reaching 00:00
//   expired   out  1      level, 1 in EXPIRED until load or rst
// BEHAVIOUR
//   - States: IDLE, RUN, PAUSE, EXPIRED. All outputs registered.
//   - Reset (rst=1 at edge): min=0, sec=0, running=0, done=0, expired=0, state=IDLE, prescaler=0.
//   - Priority per edge: rst > load > start > stop. start+stop same cycle: start wins.
//   - load (any state): min<=load_min, sec<=min(load_sec,59), state=IDLE, prescaler=0,
//     expired=0, done=0.
//   - start in IDLE/PAUSE: if {min,sec}!=0 -> RUN, prescaler=0; if 00:00 -> ignored, stays put.
//     start in RUN: no effect (prescaler not cleared). start in EXPIRED: ignored.
//   - stop in RUN -> PAUSE; min/sec/prescaler frozen. stop elsewhere: no effect.
//   - Prescaler: counts 0..TICK_DIV-1 only in RUN; tick=1 when count==TICK_DIV-1, then wraps to 0.
//   - Latency: start sampled at edge N -> first decrement at edge N+TICK_DIV, then every TICK_DIV.
//   - On tick: sec>0 -> sec-1; sec==0 & min>0 -> min-1, sec=59 (borrow).
//   - If the tick result is 00:00: same edge state=EXPIRED, running=0, done=1, expired=1.
//     done clears the next edge; expired holds.
//   - No wrap below 00:00: count never decrements in EXPIRED/IDLE/PAUSE.
//   - min arithmetic is MIN_W bits unsigned; load_min=2**MIN_W-1 legal.
//   - running is exactly (state==RUN); done never asserts without a tick in RUN.
//   - rst mid-run discards count and prescaler; no done pulse generated.
// STRUCTURE
//   - Shared package timer_pkg: state enum (IDLE,RUN,PAUSE,EXPIRED), SEC_MAX=59,
//     SEC_W=6 (also used by stopwatch).
//   - One sub-module: tick_gen #(TICK_DIV) (clk, rst, en, clr, tick) - prescaler;
//     en=running, clr on entry to RUN or load.
//   - Top holds FSM and MM:SS down-counter with borrow.
// TESTING (TICK_DIV=4)
//   1 load 00:03, start at edge N -> sec=2@N+4, 1@N+8, 0@N+12; done=1 only at N+12,
//     expired=1 from N+12, running=0.
//   2 load 01:00, start -> after first tick min=0 sec=59; after 59 more ticks done pulses once.
//   3 load 00:05, start, stop after 6 cycles -> PAUSE, values unchanged 20 cycles;
//     start -> next decrement 4 cycles later.
//   4 load 00:00, start -> stays IDLE, running=0, done never asserts; start in EXPIRED ignored.
//   5 load_sec=62 -> sec=59; start and stop same cycle from IDLE -> running=1.
//   6 rst mid-RUN -> all outputs 0 next edge; load 00:07 during RUN -> IDLE, sec=7, expired=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared timer definitions: FSM states and seconds-field constants.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_EXPIRED
  } state_e;

  localparam int unsigned     SEC_W   = 6;
  localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(59);

  // Preset seconds above 59 saturate to 59.
  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] s);
    return (s > SEC_MAX) ? SEC_MAX : s;
  endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled clocks.
module tick_gen #(
  parameter int unsigned TICK_DIV = 12_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_top;

  assign at_top = (cnt_q == CW'(TICK_DIV - 1));
  assign tick   = en && at_top;

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_top ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable MM:SS countdown timer with start/stop control and expiry flags.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12_000_000,
  parameter int unsigned MIN_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             start,
  input  logic             stop,
  output logic [MIN_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output logic             running,
  output logic             done,
  output logic             expired
);

  state_e           state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;
  logic             tg_en, tg_clr, tick;
  logic             nonzero, last_sec;

  assign nonzero  = (min_q != '0) || (sec_q != '0);
  assign last_sec = (min_q == '0) && (sec_q == SEC_W'(1));

  // The prescaler only advances on cycles that stay in RUN, so the edge that
  // pauses or reloads the timer never produces a tick.
  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (tg_en),
    .clr (tg_clr),
    .tick(tick)
  );

  // Next-state, down-counter and flag logic; priority load > start > stop.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    done_d    = 1'b0;
    expired_d = expired_q;
    tg_en     = 1'b0;
    tg_clr    = 1'b0;
    if (load) begin
      state_d   = ST_IDLE;
      min_d     = load_min;
      sec_d     = clamp_sec(load_sec);
      expired_d = 1'b0;
      tg_clr    = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (start && nonzero) begin
            state_d = ST_RUN;
            tg_clr  = 1'b1;
          end
        end
        ST_RUN: begin
          if (stop && !start) begin
            state_d = ST_PAUSE;
          end else begin
            tg_en = 1'b1;
            if (tick) begin
              if (sec_q != '0) begin
                sec_d = sec_q - SEC_W'(1);
              end else begin
                min_d = min_q - MIN_W'(1);
                sec_d = SEC_MAX;
              end
              if (last_sec) begin
                state_d   = ST_EXPIRED;
                done_d    = 1'b1;
                expired_d = 1'b1;
              end
            end
          end
        end
        ST_EXPIRED: ;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign min     = min_q;
  assign sec     = sec_q;
  assign running = (state_q == ST_RUN);
  assign done    = done_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random
// stimulus compared every cycle against a total-seconds reference model.
module tb_countdown_timer;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned MIN_W    = 6;

  logic             clk = 1'b0;
  logic             rst, load, start, stop;
  logic [MIN_W-1:0] load_min;
  logic [5:0]       load_sec;
  logic [MIN_W-1:0] min;
  logic [5:0]       sec;
  logic             running, done, expired;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: remaining time as plain seconds.
  int m_total = 0;
  int m_mode  = 0;   // 0 idle, 1 run, 2 pause, 3 expired
  int m_phase = 0;   // enabled cycles since RUN entry / last tick
  bit m_done  = 1'b0;
  bit m_exp   = 1'b0;

  countdown_timer #(
    .TICK_DIV(TICK_DIV),
    .MIN_W   (MIN_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_min(load_min),
    .load_sec(load_sec),
    .start   (start),
    .stop    (stop),
    .min     (min),
    .sec     (sec),
    .running (running),
    .done    (done),
    .expired (expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the inputs sampled at each rising edge.
  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_total = 0; m_mode = 0; m_phase = 0; m_exp = 1'b0;
    end else if (load) begin
      m_total = int'(load_min) * 60 + ((load_sec > 6'd59) ? 59 : int'(load_sec));
      m_mode  = 0; m_phase = 0; m_exp = 1'b0;
    end else if ((m_mode == 0 || m_mode == 2) && start) begin
      if (m_total != 0) begin
        m_mode = 1; m_phase = 0;
      end
    end else if (m_mode == 1 && stop && !start) begin
      m_mode = 2;
    end else if (m_mode == 1) begin
      m_phase++;
      if (m_phase == TICK_DIV) begin
        m_phase = 0;
        m_total--;
        if (m_total == 0) begin
          m_mode = 3; m_done = 1'b1; m_exp = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("min",     int'(min),     m_total / 60);
      chk("sec",     int'(sec),     m_total % 60);
      chk("running", int'(running), int'(m_mode == 1));
      chk("done",    int'(done),    int'(m_done));
      chk("expired", int'(expired), int'(m_exp));
    end
  end

  // Apply one cycle of inputs; returns 2 time units after the sampling edge.
  task automatic cyc(input bit r, input bit ld, input int lm, input int ls,
                     input bit st, input bit sp);
    rst = r; load = ld; load_min = MIN_W'(lm); load_sec = 6'(ls);
    start = st; stop = sp;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  int done_cnt;

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
    load_min = '0; load_sec = '0;
    cyc(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_min", int'(min), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_expired", int'(expired), 0);

    // 00:03 countdown, start sampled at edge N.
    cyc(0, 1, 0, 3, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("s1_run", int'(running), 1);
    idle(3);  chk("s1_n3_sec", int'(sec), 3);
    idle(1);  chk("s1_n4_sec", int'(sec), 2);
    idle(4);  chk("s1_n8_sec", int'(sec), 1);
    idle(3);  chk("s1_n11_done", int'(done), 0);
    idle(1);
    chk("s1_n12_sec", int'(sec), 0);
    chk("s1_n12_done", int'(done), 1);
    chk("s1_n12_exp", int'(expired), 1);
    chk("s1_n12_run", int'(running), 0);
    idle(1);
    chk("s1_n13_done", int'(done), 0);
    chk("s1_n13_exp", int'(expired), 1);
    // start in EXPIRED is ignored.
    cyc(0, 0, 0, 0, 1, 0);
    chk("s4_exp_start_run", int'(running), 0);
    chk("s4_exp_start_exp", int'(expired), 1);

    // 01:00 borrow, then a single done pulse.
    cyc(0, 1, 1, 0, 0, 0);
    chk("s2_load_exp", int'(expired), 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(4);
    chk("s2_borrow_min", int'(min), 0);
    chk("s2_borrow_sec", int'(sec), 59);
    done_cnt = 0;
    for (int i = 0; i < 59 * 4 + 6; i++) begin
      idle(1);
      if (done) done_cnt++;
    end
    chk("s2_done_pulses", done_cnt, 1);

    // 00:05 pause and resume.
    cyc(0, 1, 0, 5, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(5);
    cyc(0, 0, 0, 0, 0, 1);
    chk("s3_paused_run", int'(running), 0);
    chk("s3_paused_sec", int'(sec), 4);
    idle(20);
    chk("s3_frozen_sec", int'(sec), 4);
    cyc(0, 0, 0, 0, 1, 0);
    idle(3);  chk("s3_resume3_sec", int'(sec), 4);
    idle(1);  chk("s3_resume4_sec", int'(sec), 3);

    // 00:00 start is ignored.
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("s4_zero_run", int'(running), 0);
    idle(8);
    chk("s4_zero_done", int'(done), 0);

    // Clamp and start+stop from IDLE.
    cyc(0, 1, 2, 62, 0, 0);
    chk("s5_clamp_sec", int'(sec), 59);
    chk("s5_clamp_min", int'(min), 2);
    cyc(0, 0, 0, 0, 1, 1);
    chk("s5_start_stop_run", int'(running), 1);

    // Reset mid-run, then reload during RUN.
    idle(5);
    cyc(1, 0, 0, 0, 0, 0);
    chk("s6_rst_min", int'(min), 0);
    chk("s6_rst_sec", int'(sec), 0);
    chk("s6_rst_run", int'(running), 0);
    cyc(0, 1, 0, 9, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(3);
    cyc(0, 1, 0, 7, 0, 0);
    chk("s6_reload_sec", int'(sec), 7);
    chk("s6_reload_run", int'(running), 0);
    chk("s6_reload_exp", int'(expired), 0);

    // Max minutes preset.
    cyc(0, 1, 63, 59, 0, 0);
    chk("max_min", int'(min), 63);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      automatic int  p  = int'($urandom_range(0, 999));
      automatic bit  r  = (p < 5);
      automatic bit  ld = ($urandom_range(0, 99) < 3);
      automatic int  lm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63))
                                                      : int'($urandom_range(0, 1));
      automatic int  ls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63))
                                                      : int'($urandom_range(0, 6));
      automatic bit  st = ($urandom_range(0, 99) < 10);
      automatic bit  sp = ($urandom_range(0, 99) < 4);
      cyc(r, ld, lm, ls, st, sp);
    end

    idle(2);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
